fft2_out_serializer: RTL and testbench

Output-side companion to the radix-2 butterfly `fft2`. It accepts a full butterfly result pair (x0, x1, each complex IEEE-754 single precision) per transfer, buffers pairs in a small FIFO, and emits them as a serial complex-sample stream with valid/ready handshake: x0 first, then x1. It also marks frame boundaries and flags NaN/Inf words. It sits between the butterfly output registers and downstream storage or host capture.

---
 rtl/fft2_out_serializer.sv | 66 ++++++
 tb/tb_fft2_out_serializer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft2_out_serializer.sv
// fft2_out_serializer: FIFO of butterfly pairs (in_valid/in_ready, x0_*/x1_*) serialized as x0 then x1 words (out_valid/out_ready, out_re/out_img/out_sel) with frame out_last, NaN/Inf out_special and sticky drop_err
module fft2_out_serializer #(
  parameter int DEPTH = 4,
  parameter int FRAME_PAIRS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x0_re,
  input  logic [31:0] x0_img,
  input  logic [31:0] x1_re,
  input  logic [31:0] x1_img,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_re,
  output logic [31:0] out_img,
  output logic        out_sel,
  output logic        out_last,
  output logic        out_special,
  output logic        drop_err
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = FRAME_PAIRS > 1 ? $clog2(FRAME_PAIRS) : 1;
  logic [127:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [FW-1:0] fc;
  logic          ph, push, pop, fc_end;
  logic [63:0]   word;
  assign in_ready  = count != CW'(DEPTH);
  assign out_valid = count != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && ph;
  assign fc_end    = fc == FW'(FRAME_PAIRS - 1);
  assign word      = ph ? mem[rptr][63:0] : mem[rptr][127:64];
  always_comb begin
    out_re      = out_valid ? word[63:32] : '0;
    out_img     = out_valid ? word[31:0] : '0;
    out_sel     = ph;
    out_last    = out_valid && ph && fc_end;
    out_special = out_valid && (&out_re[30:23] || &out_img[30:23]);
  end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= {x0_re, x0_img, x1_re, x1_img};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      fc       <= '0;
      ph       <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (out_valid && out_ready) ph <= !ph;
      if (pop) begin
        rptr <= rptr + 1'b1;
        fc   <= fc_end ? '0 : fc + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
      if (in_valid && !in_ready) drop_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fft2_out_serializer.sv
// tb_fft2_out_serializer: randomized and directed checks of fft2_out_serializer against a word-queue reference model
module tb_fft2_out_serializer;
  localparam int DEPTH = 4;
  localparam int FP = 4;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [31:0] x0_re = 0, x0_img = 0, x1_re = 0, x1_img = 0;
  logic in_ready, out_valid, out_sel, out_last, out_special, drop_err;
  logic [31:0] out_re, out_img;
  int errs = 0, checks = 0;
  typedef struct packed {logic [31:0] re; logic [31:0] img; logic sel;} word_t;
  word_t wq[$];
  int nout = 0;
  bit mdrop = 0;

  fft2_out_serializer #(.DEPTH(DEPTH), .FRAME_PAIRS(FP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x0_re(x0_re), .x0_img(x0_img), .x1_re(x1_re), .x1_img(x1_img),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_img(out_img),
    .out_sel(out_sel), .out_last(out_last), .out_special(out_special), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  function automatic bit m_valid();
    return wq.size() != 0;
  endfunction
  function automatic bit m_ready();
    return (wq.size() + 1) / 2 != DEPTH;
  endfunction
  function automatic logic [31:0] m_re();
    return m_valid() ? wq[0].re : 32'h0;
  endfunction
  function automatic logic [31:0] m_img();
    return m_valid() ? wq[0].img : 32'h0;
  endfunction
  function automatic bit m_sel();
    return m_valid() ? wq[0].sel : 1'b0;
  endfunction
  function automatic bit m_last();
    return m_valid() && wq[0].sel && (nout % (2 * FP) == 2 * FP - 1);
  endfunction
  function automatic bit m_special();
    logic [31:0] r, i;
    r = m_re();
    i = m_img();
    return m_valid() && (r[30:23] == 8'hFF || i[30:23] == 8'hFF);
  endfunction
  function automatic logic [127:0] rnd_pair();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic cyc(input bit iv, input logic [127:0] p, input bit ordy);
    bit rdy, pop;
    rdy = m_ready();
    pop = m_valid() && ordy;
    in_valid = iv;
    {x0_re, x0_img, x1_re, x1_img} = p;
    out_ready = ordy;
    @(posedge clk);
    if (pop) begin
      void'(wq.pop_front());
      nout++;
    end
    if (iv && rdy) begin
      wq.push_back(word_t'({p[127:96], p[95:64], 1'b0}));
      wq.push_back(word_t'({p[63:32], p[31:0], 1'b1}));
    end
    if (iv && !rdy) mdrop = 1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1;
    in_valid = 0;
    #2 rst = 0;
    wq.delete();
    nout = 0;
    mdrop = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_re, out_img, out_sel, out_last, out_special, drop_err} !== {1'b1, 1'b0, 64'h0, 4'h0})
      begin errs++; $display("FAIL reset_state got rdy=%b vld=%b re=%h img=%h sel=%b last=%b sp=%b drop=%b want rdy=1 others 0",
        in_ready, out_valid, out_re, out_img, out_sel, out_last, out_special, drop_err); end
    #1 rst = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    cyc(1, 128'h3f491a30_4246570a_3f15c290_c14c0000, 1);
    checks++;
    if ({out_valid, out_sel, out_re, out_img} !== {2'b10, 64'h3f491a30_4246570a})
      begin errs++; $display("FAIL single_x0 got vld=%b sel=%b re=%h img=%h want 1 0 3f491a30 4246570a", out_valid, out_sel, out_re, out_img); end
    cyc(0, 0, 1);
    checks++;
    if ({out_valid, out_sel, out_re, out_img} !== {2'b11, 64'h3f15c290_c14c0000})
      begin errs++; $display("FAIL single_x1 got vld=%b sel=%b re=%h img=%h want 1 1 3f15c290 c14c0000", out_valid, out_sel, out_re, out_img); end
    cyc(0, 0, 1);
    checks++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL single_empty got vld=%b want 0", out_valid); end
  endtask

  task automatic test_fill();
    logic [127:0] pr[5];
    logic [31:0] hre, himg;
    logic hsel;
    for (int i = 0; i < 5; i++) begin
      pr[i] = rnd_pair();
      cyc(1, pr[i], 0);
      if (i == 3) begin
        checks++;
        if (in_ready !== 1'b0) begin errs++; $display("FAIL fill_full got in_ready=%b want 0", in_ready); end
      end
    end
    checks++;
    if ({drop_err, in_ready} !== 2'b10) begin errs++; $display("FAIL fill_drop got drop=%b rdy=%b want 1 0", drop_err, in_ready); end
    hre = out_re;
    himg = out_img;
    hsel = out_sel;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    checks++;
    if ({out_valid, out_re, out_img, out_sel, out_last} !== {1'b1, hre, himg, hsel, 1'b0} || hre !== pr[0][127:96])
      begin errs++; $display("FAIL fill_hold got re=%h img=%h sel=%b want re=%h img=%h sel=%b", out_re, out_img, out_sel, pr[0][127:96], himg, hsel); end
    for (int w = 0; w < 8; w++) begin
      logic [63:0] e;
      logic [127:0] pp;
      pp = pr[w / 2];
      e = w % 2 ? pp[63:0] : pp[127:64];
      checks++;
      if ({out_valid, out_sel, out_re, out_img} !== {1'b1, w % 2 == 1, e})
        begin errs++; $display("FAIL drain_word%0d got vld=%b sel=%b data=%h%h want 1 %0d %h", w, out_valid, out_sel, out_re, out_img, w % 2, e); end
      cyc(0, 0, 1);
    end
    checks++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL drain_empty got vld=%b want 0", out_valid); end
  endtask

  task automatic test_frame();
    int w = 0, sent = 0, n = 0;
    do_reset();
    while (w < 16 && n < 200) begin
      bit iv;
      if (out_valid) begin
        w++;
        checks++;
        if (out_last !== (w == 8 || w == 16) || (out_last && out_sel !== 1'b1))
          begin errs++; $display("FAIL frame_word%0d got last=%b sel=%b want last=%b sel=1", w, out_last, out_sel, w == 8 || w == 16); end
      end
      iv = sent < 8 && m_ready();
      if (iv) sent++;
      cyc(iv, rnd_pair(), 1);
      n++;
    end
    checks++;
    if (w != 16) begin errs++; $display("FAIL frame_count got %0d words want 16", w); end
  endtask

  task automatic test_special();
    cyc(1, 128'h7fc00000_3fcae148_3fcae148_ff800000, 1);
    checks++;
    if ({out_special, out_sel, out_re, out_img} !== {2'b10, 64'h7fc00000_3fcae148})
      begin errs++; $display("FAIL special_x0 got sp=%b sel=%b re=%h img=%h want 1 0 7fc00000 3fcae148", out_special, out_sel, out_re, out_img); end
    cyc(0, 0, 1);
    checks++;
    if ({out_special, out_sel, out_re, out_img} !== {2'b11, 64'h3fcae148_ff800000})
      begin errs++; $display("FAIL special_x1 got sp=%b sel=%b re=%h img=%h want 1 1 3fcae148 ff800000", out_special, out_sel, out_re, out_img); end
    cyc(0, 0, 1);
    checks++;
    if (out_special !== 1'b0) begin errs++; $display("FAIL special_idle got sp=%b want 0", out_special); end
  endtask

  task automatic test_random();
    int acc = 0, n = 0, start = nout;
    while ((acc < 100 || wq.size() != 0) && n < 3000) begin
      bit iv;
      checks++;
      if ({out_valid, in_ready, out_re, out_img, out_sel, out_last, out_special, drop_err} !==
          {m_valid(), m_ready(), m_re(), m_img(), m_sel(), m_last(), m_special(), mdrop})
        begin errs++; $display("FAIL random_cyc%0d got vld=%b rdy=%b re=%h img=%h sel=%b last=%b sp=%b drop=%b want %b %b %h %h %b %b %b %b",
          n, out_valid, in_ready, out_re, out_img, out_sel, out_last, out_special, drop_err,
          m_valid(), m_ready(), m_re(), m_img(), m_sel(), m_last(), m_special(), mdrop); end
      iv = acc < 100 && $urandom_range(0, 3) != 0;
      if (iv && m_ready()) acc++;
      cyc(iv, rnd_pair(), $urandom_range(0, 1) == 1);
      n++;
    end
    checks++;
    if (acc != 100 || nout - start != 200 || wq.size() != 0)
      begin errs++; $display("FAIL random_total got pairs=%0d words=%0d left=%0d want 100 200 0", acc, nout - start, wq.size()); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] a;
    int w = 0, sent = 1, n = 0;
    for (int i = 0; i < 3; i++) cyc(1, rnd_pair(), 0);
    rst = 1;
    #1;
    checks++;
    if ({out_valid, in_ready, drop_err} !== 3'b010)
      begin errs++; $display("FAIL reset_mid got vld=%b rdy=%b drop=%b want 0 1 0", out_valid, in_ready, drop_err); end
    #1 rst = 0;
    wq.delete();
    nout = 0;
    mdrop = 0;
    a = rnd_pair();
    cyc(1, a, 0);
    checks++;
    if ({out_valid, out_sel, out_re, out_img} !== {2'b10, a[127:64]})
      begin errs++; $display("FAIL reset_first got vld=%b sel=%b data=%h%h want 1 0 %h", out_valid, out_sel, out_re, out_img, a[127:64]); end
    while (w < 8 && n < 100) begin
      bit iv;
      if (out_valid) begin
        w++;
        checks++;
        if (out_last !== (w == 8)) begin errs++; $display("FAIL reset_frame_word%0d got last=%b want %b", w, out_last, w == 8); end
      end
      iv = sent < 4 && m_ready();
      if (iv) sent++;
      cyc(iv, rnd_pair(), 1);
      n++;
    end
    checks++;
    if (w != 8) begin errs++; $display("FAIL reset_frame_count got %0d words want 8", w); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_frame();
    test_special();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
